// File: rtl/galaksija_pkg.sv
// Shared definitions for the Galaksija keyboard matrix: matrix index
// constants, the queued key-event record and the apply FSM states.
package galaksija_pkg;

    // Sentinel returned for scancodes that have no matrix position.
    localparam logic [5:0] INDEX_NONE = 6'h00;

    localparam logic [5:0] KEY_A      = 6'h01;
    localparam logic [5:0] KEY_Z      = 6'h1A;
    localparam logic [5:0] KEY_UP     = 6'h1B;
    localparam logic [5:0] KEY_DOWN   = 6'h1C;
    localparam logic [5:0] KEY_LEFT   = 6'h1D;
    localparam logic [5:0] KEY_RIGHT  = 6'h1E;
    localparam logic [5:0] KEY_SPACE  = 6'h1F;
    localparam logic [5:0] KEY_0      = 6'h20;
    localparam logic [5:0] KEY_SEMI   = 6'h2A;
    localparam logic [5:0] KEY_COLON  = 6'h2B;
    localparam logic [5:0] KEY_COMMA  = 6'h2C;
    localparam logic [5:0] KEY_EQUAL  = 6'h2D;
    localparam logic [5:0] KEY_PERIOD = 6'h2E;
    localparam logic [5:0] KEY_SLASH  = 6'h2F;
    localparam logic [5:0] KEY_RETURN = 6'h30;
    localparam logic [5:0] KEY_BRK    = 6'h31;
    localparam logic [5:0] KEY_DEL    = 6'h33;
    localparam logic [5:0] KEY_LIST   = 6'h34;
    localparam logic [5:0] KEY_SHIFT  = 6'h35;

    // Width of the hold-timer down-counter.
    localparam int HOLD_CNT_W = 20;

    // One queued event: make (1) or break (0) applied to a matrix index.
    typedef struct packed {
        logic       make;
        logic [5:0] index;
    } key_event_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_HOLD
    } apply_state_t;

endpackage

// File: rtl/ps2_key_matrix_if.sv
// Bus between the PS/2 decoder / CPU read mux and the key matrix block.
interface ps2_key_matrix_if;
    logic [10:0] ps2_key;
    logic [5:0]  addr;
    logic        key_out;
    logic        overflow;
    logic        busy;

    modport master (
        output ps2_key,
        output addr,
        input  key_out,
        input  overflow,
        input  busy
    );

    modport slave (
        input  ps2_key,
        input  addr,
        output key_out,
        output overflow,
        output busy
    );
endinterface

// File: rtl/ps2_to_galaksija_index.sv
// Combinational translation of a PS/2 set-2 scancode (with E0 flag) to a
// Galaksija matrix index. Unmapped codes yield valid=0 and INDEX_NONE.
module ps2_to_galaksija_index
    import galaksija_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       valid,
    output logic [5:0] index
);

    // Lookup: E0 codes carry only the cursor keys; everything else is plain.
    always_comb begin
        index = INDEX_NONE;
        if (ext) begin
            case (code)
                8'h75:   index = KEY_UP;
                8'h72:   index = KEY_DOWN;
                8'h6B:   index = KEY_LEFT;
                8'h74:   index = KEY_RIGHT;
                default: index = INDEX_NONE;
            endcase
        end else begin
            case (code)
                8'h1C: index = KEY_A;          8'h32: index = KEY_A + 6'd1;
                8'h21: index = KEY_A + 6'd2;   8'h23: index = KEY_A + 6'd3;
                8'h24: index = KEY_A + 6'd4;   8'h2B: index = KEY_A + 6'd5;
                8'h34: index = KEY_A + 6'd6;   8'h33: index = KEY_A + 6'd7;
                8'h43: index = KEY_A + 6'd8;   8'h3B: index = KEY_A + 6'd9;
                8'h42: index = KEY_A + 6'd10;  8'h4B: index = KEY_A + 6'd11;
                8'h3A: index = KEY_A + 6'd12;  8'h31: index = KEY_A + 6'd13;
                8'h44: index = KEY_A + 6'd14;  8'h4D: index = KEY_A + 6'd15;
                8'h15: index = KEY_A + 6'd16;  8'h2D: index = KEY_A + 6'd17;
                8'h1B: index = KEY_A + 6'd18;  8'h2C: index = KEY_A + 6'd19;
                8'h3C: index = KEY_A + 6'd20;  8'h2A: index = KEY_A + 6'd21;
                8'h1D: index = KEY_A + 6'd22;  8'h22: index = KEY_A + 6'd23;
                8'h35: index = KEY_A + 6'd24;  8'h1A: index = KEY_Z;
                8'h29: index = KEY_SPACE;
                8'h45: index = KEY_0;          8'h16: index = KEY_0 + 6'd1;
                8'h1E: index = KEY_0 + 6'd2;   8'h26: index = KEY_0 + 6'd3;
                8'h25: index = KEY_0 + 6'd4;   8'h2E: index = KEY_0 + 6'd5;
                8'h36: index = KEY_0 + 6'd6;   8'h3D: index = KEY_0 + 6'd7;
                8'h3E: index = KEY_0 + 6'd8;   8'h46: index = KEY_0 + 6'd9;
                8'h4C: index = KEY_SEMI;
                8'h52: index = KEY_COLON;      // apostrophe key, beside ';'
                8'h41: index = KEY_COMMA;
                8'h55: index = KEY_EQUAL;
                8'h49: index = KEY_PERIOD;
                8'h4A: index = KEY_SLASH;
                8'h5A: index = KEY_RETURN;
                8'h76: index = KEY_BRK;
                8'h66: index = KEY_DEL;
                8'h0D: index = KEY_LIST;
                8'h12: index = KEY_SHIFT;
                8'h59: index = KEY_SHIFT;
                default: index = INDEX_NONE;
            endcase
        end
    end

    assign valid = (index != INDEX_NONE);

endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 event to Galaksija 64-key matrix. Events are queued and applied one
// at a time, each followed by a hold so the polled CPU routine sees taps.
module ps2_key_matrix
    import galaksija_pkg::*;
#(
    parameter int F_CLK      = 25000000,
    parameter int HOLD_US    = 20000,
    parameter int FIFO_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    ps2_key_matrix_if.slave bus
);

    localparam int HOLD_CYCLES = (F_CLK / 1000000) * HOLD_US;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

    logic                  tog_p0;
    logic                  new_evt;
    logic                  map_vld;
    logic [5:0]            map_idx;
    key_event_t            fifo_mem [FIFO_DEPTH];
    key_event_t            head;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic [PTR_W:0]        count_nxt;
    logic                  push_req;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  overflow_q;
    logic                  busy_q;
    apply_state_t          state;
    apply_state_t          state_nxt;
    logic [HOLD_CNT_W-1:0] hold_cnt;
    logic [63:0]           matrix;

    ps2_to_galaksija_index u_xlate (
        .ext   (bus.ps2_key[8]),
        .code  (bus.ps2_key[7:0]),
        .valid (map_vld),
        .index (map_idx)
    );

    assign new_evt   = (bus.ps2_key[10] != tog_p0);
    assign push_req  = new_evt && map_vld;
    assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop       = (state == ST_APPLY);
    // A full queue still accepts when the head leaves in the same cycle.
    assign push      = push_req && (!full || pop);
    assign head      = fifo_mem[rd_ptr];
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // Toggle tracker; reset loads the live level so no phantom event follows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tog_p0 <= bus.ps2_key[10];
        else       tog_p0 <= bus.ps2_key[10];
    end

    // Queue storage, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{make: bus.ps2_key[9], index: map_idx};
    end

    // Queue pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            if (push_req && full && !pop) overflow_q <= 1'b1;
        end
    end

    // Apply FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Apply FSM next state: one APPLY cycle, then hold until the timer expires.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (count != '0) state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_HOLD;
            ST_HOLD:  if (hold_cnt == '0) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Matrix update at APPLY, hold countdown, and registered busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix   <= '0;
            hold_cnt <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (state == ST_APPLY) begin
                matrix[head.index] <= head.make;
                hold_cnt           <= HOLD_LOAD;
            end else if (state == ST_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
            end
            busy_q <= (count_nxt != '0) || (state_nxt != ST_IDLE);
        end
    end

    // Indices 0 and 0x36-0x3F are never written, so they always read released.
    assign bus.key_out  = ~matrix[bus.addr];
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_ps2_key_matrix.sv
// Testbench for ps2_key_matrix: directed scenarios plus randomized traffic,
// checked every cycle against an event-schedule model.
`timescale 1ns/10ps
module tb_ps2_key_matrix;

    localparam int F_CLK   = 25000000;
    localparam int HOLD_US = 1;
    localparam int DEPTH   = 8;
    localparam int H       = (F_CLK / 1000000) * HOLD_US;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ps2_key_matrix_if bus ();

    ps2_key_matrix #(.F_CLK(F_CLK), .HOLD_US(HOLD_US), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference mapping and key lists
    logic [5:0]  lut [512];
    logic [8:0]  mapped_keys [$];
    byte unsigned letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                        8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                        8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    byte unsigned digit_codes [10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    byte unsigned punct_codes [6]   = '{8'h4C,8'h52,8'h41,8'h55,8'h49,8'h4A};

    function automatic void add_key(input bit ext, input logic [7:0] code, input int idx);
        lut[{ext, code}] = 6'(idx);
        mapped_keys.push_back({ext, code});
    endfunction

    // Model: each accepted event is applied at max(detect+2, previous+H+2).
    typedef struct {
        int det;
        int app;
        bit mk;
        int idx;
    } mev_t;

    mev_t      evq [$];
    bit [63:0] m_mat    = '0;
    bit        m_ovf    = 1'b0;
    int        cyc      = 0;
    int        last_app = -1000000;
    bit        tog_prev = 1'b0;
    bit        chk_en   = 1'b0;
    int        busy_hi_cnt = 0;

    function automatic bit m_busy();
        foreach (evq[i])
            if (evq[i].det <= cyc && cyc <= evq[i].app + H - 1) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        int  idx;
        int  occ;
        bit  popn;
        mev_t e;
        if (reset) begin
            evq.delete();
            m_mat    = '0;
            m_ovf    = 1'b0;
            last_app = -1000000;
            tog_prev = bus.ps2_key[10];
        end else begin
            cyc++;
            if (bus.ps2_key[10] != tog_prev) begin
                tog_prev = bus.ps2_key[10];
                idx = int'(lut[bus.ps2_key[8:0]]);
                if (idx != 0) begin
                    occ  = 0;
                    popn = 1'b0;
                    foreach (evq[i]) begin
                        if (evq[i].app >= cyc) occ++;
                        if (evq[i].app == cyc) popn = 1'b1;
                    end
                    if (occ < DEPTH || popn) begin
                        e.det = cyc;
                        e.app = (cyc + 2 > last_app + H + 2) ? cyc + 2 : last_app + H + 2;
                        e.mk  = bus.ps2_key[9];
                        e.idx = idx;
                        last_app = e.app;
                        evq.push_back(e);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            foreach (evq[i])
                if (evq[i].app == cyc) m_mat[evq[i].idx] = evq[i].mk;
            while (evq.size() > 0 && evq[0].app + H < cyc) void'(evq.pop_front());
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (bus.busy) busy_hi_cnt++;
        if (!reset && chk_en) begin
            chk("busy", int'(bus.busy), int'(m_busy()));
            chk("overflow", int'(bus.overflow), int'(m_ovf));
            chk("key_out", int'(bus.key_out), int'(!m_mat[bus.addr]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input bit mk, input bit ext, input logic [7:0] code);
        bus.ps2_key = {~bus.ps2_key[10], mk, ext, code};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    // Walk every address within one clock phase; bit set = expected pressed.
    task automatic sweep(input string name, input logic [63:0] pressed);
        for (int i = 0; i < 64; i++) begin
            bus.addr = 6'(i);
            #0.05;
            chk(name, int'(bus.key_out), int'(!pressed[i]));
        end
    endtask

    initial begin
        int first;
        int lows;
        int gap;
        logic [8:0] k;

        for (int i = 0; i < 512; i++) lut[i] = 6'h00;
        for (int i = 0; i < 26; i++) add_key(1'b0, letter_codes[i], 1 + i);
        add_key(1'b1, 8'h75, 6'h1B);
        add_key(1'b1, 8'h72, 6'h1C);
        add_key(1'b1, 8'h6B, 6'h1D);
        add_key(1'b1, 8'h74, 6'h1E);
        add_key(1'b0, 8'h29, 6'h1F);
        for (int i = 0; i < 10; i++) add_key(1'b0, digit_codes[i], 6'h20 + i);
        for (int i = 0; i < 6; i++) add_key(1'b0, punct_codes[i], 6'h2A + i);
        add_key(1'b0, 8'h5A, 6'h30);
        add_key(1'b0, 8'h76, 6'h31);
        add_key(1'b0, 8'h66, 6'h33);
        add_key(1'b0, 8'h0D, 6'h34);
        add_key(1'b0, 8'h12, 6'h35);
        add_key(1'b0, 8'h59, 6'h35);

        bus.ps2_key = '0;
        bus.addr    = '0;
        step(3);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        sweep("rst_key", 64'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        step(2);

        // Tap A: make, break two cycles later
        bus.addr = 6'h01;
        send(1'b1, 1'b0, 8'h1C);
        first = -1;
        lows  = 0;
        for (int j = 0; j < 45; j++) begin
            @(negedge clk);
            if (bus.key_out == 1'b0) begin
                if (first < 0) first = j;
                lows++;
            end
            if (j == 1) begin
                @(posedge clk);
                #1;
                send(1'b0, 1'b0, 8'h1C);
            end
        end
        chk("tap_first_low", first, 3);
        chk("tap_low_cycles", lows, 27);
        step(40);

        // Extended arrow vs. same code without E0
        bus.addr = 6'h1B;
        send(1'b1, 1'b1, 8'h75);
        step(4);
        chk("arrow_ext", int'(bus.key_out), 0);
        step(H + 5);
        send(1'b1, 1'b0, 8'h75);
        step(1);
        chk("arrow_noext_busy", int'(bus.busy), 0);
        step(1);
        chk("arrow_noext_busy2", int'(bus.busy), 0);

        // Overflow: ten makes on consecutive cycles
        do_reset();
        busy_hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 1'b0, letter_codes[i]);
            step(1);
        end
        chk("ovf_flag", int'(bus.overflow), 1);
        step(9 * (H + 2) + 20);
        chk("ovf_busy_cycles", busy_hi_cnt, 243);
        sweep("ovf_matrix", 64'h0000_0000_0000_03FE);

        // Shift plus '0'
        do_reset();
        send(1'b1, 1'b0, 8'h12);
        step(1);
        send(1'b1, 1'b0, 8'h45);
        step(2 * (H + 2) + 5);
        sweep("shift_zero", 64'h0020_0001_0000_0000);

        // Reset during HOLD with a full queue
        do_reset();
        for (int i = 0; i < 12; i++) begin
            send(1'b1, 1'b0, letter_codes[i]);
            step(1);
        end
        step(10);
        chk("pre_rst_busy", int'(bus.busy), 1);
        chk("pre_rst_ovf", int'(bus.overflow), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_ovf", int'(bus.overflow), 0);
        sweep("rst_mid_key", 64'h0);
        step(2);
        reset = 1'b0;
        busy_hi_cnt = 0;
        step(100);
        chk("post_rst_idle", busy_hi_cnt, 0);
        sweep("post_rst_key", 64'h0);

        // Unmapped code (F12)
        send(1'b1, 1'b0, 8'h07);
        busy_hi_cnt = 0;
        step(5);
        chk("unmapped_busy", busy_hi_cnt, 0);
        sweep("unmapped_key", 64'h0);

        // Randomized traffic with bursts, gaps and occasional resets
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) != 0)
                k = mapped_keys[$urandom_range(0, mapped_keys.size() - 1)];
            else
                k = 9'($urandom);
            send(1'($urandom), k[8], k[7:0]);
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 60);
            repeat (gap + 1) begin
                step(1);
                bus.addr = 6'($urandom);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end
        step(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_key_matrix.md
# ps2_key_matrix

Converts PS/2 key events from the `ps2` decoder into the Galaksija 64-key matrix read by the CPU at 0x2000–0x203F. It sits between `ps2` (upstream) and the CPU bus read mux (downstream), on the 25 MHz system clock. Events are queued and applied one at a time with a minimum dwell between matrix changes, so a short tap is still seen by the slow (3.072 MHz, polled) keyboard routine.

## Interface
- `F_CLK`, 25000000: system clock in Hz.
- `HOLD_US`, 20000: minimum time between consecutive matrix updates, in µs (one 50 Hz frame).
- `FIFO_DEPTH`, 8: event queue depth; must be a power of two, ≥2.
- `clk` in 1: system clock, 25 MHz.
- `reset` in 1: asynchronous reset, active-high.
- `ps2_key` in 11: [10] toggles once per new event, [9] 1=make/0=break, [8] E0-extended, [7:0] scancode.
- `addr` in 6: CPU address bits [5:0] from the bus.
- `key_out` out 1: matrix bit for `addr`; 0 = key pressed.
- `overflow` out 1: sticky; set when a mapped event is dropped because the queue is full.
- `busy` out 1: queue not empty, or hold timer running.

## Operation
- Edge detect: register `ps2_key[10]`. A differing value is a new event, captured from `ps2_key[9:0]` on that cycle.
- Translation: {extended, scancode} maps to a 6-bit matrix index:
  - A–Z → 0x01–0x1A.
  - Up/Down/Left/Right (E0 75/72/6B/74) → 0x1B–0x1E; Space 0x29 → 0x1F.
  - Digits 0–9 → 0x20–0x29.
  - ; : , = . / → 0x2A–0x2F.
  - Return 0x5A → 0x30; Esc 0x76 → 0x31 (BRK); Backspace 0x66 → 0x33 (DEL); Tab 0x0D → 0x34 (LIST).
  - Left and right Shift (0x12, 0x59) → 0x35.
  - Any other code is unmapped and dropped; it is never queued.
- Queue: FIFO of {make, index[5:0]}, 7 bits wide.
  - Push on a mapped event.
  - If full and no pop in the same cycle: drop the event and set `overflow`.
  - If full and a pop occurs in the same cycle: accept the push.
- Apply FSM:
  - IDLE: if queue non-empty → APPLY.
  - APPLY, one cycle: pop the head. Make sets `matrix[index]=1`; break clears it. Load the hold counter with HOLD_CYCLES−1 → HOLD.
  - HOLD: decrement the counter; at 0 → IDLE.
- HOLD_CYCLES = (F_CLK/1000000)·HOLD_US; default is 500000, in a 20-bit counter.
- A repeated make on an already-set bit (typematic) is applied normally: the bit stays set and the hold runs.
- `key_out = ~matrix[addr]`. Index 0 and 0x36–0x3F always read 1.
- `overflow` clears only on reset.

## Timing
- Reset values, asserted asynchronously:
  - all matrix bits 0 (`key_out`=1 for every `addr`);
  - queue empty; FSM in IDLE; `overflow`=0; `busy`=0;
  - the toggle register loads the current `ps2_key[10]`, so no spurious event follows reset.
- Reset asserted mid-HOLD or with a non-empty queue discards all pending events.
- Latency from toggle edge:
  - cycle 0: detect and push;
  - cycle 1: IDLE sees the queue non-empty;
  - cycle 2: APPLY;
  - the matrix bit is visible from cycle 3.
- `key_out` is combinational from `addr` and the matrix register, so the CPU reads it in the same cycle.
- Spacing between two applied events is exactly HOLD_CYCLES+2 clocks.
- `busy` is registered and reflects the state and queue occupancy of the current cycle.

## Structure
- A shared package `galaksija_pkg` holds:
  - matrix index constants (KEY_A=0x01 … KEY_SHIFT=0x35);
  - the event struct type {make, index};
  - the INDEX_NONE sentinel (0x00) for unmapped codes.
- One sub-module, `ps2_to_galaksija_index`: purely combinational, {ext, code} → {valid, index[5:0]}.
- Queue and FSM live in the top of this block.

## Test plan
- Tap A (HOLD_US=1 in sim, F_CLK=25e6 → 25-cycle hold):
  - toggle with make, code 0x1C, then 2 cycles later break 0x1C;
  - `addr`=0x01 reads 0 from cycle 3 for exactly 27 cycles, then reads 1.
- Extended arrow:
  - make with ext=1, code 0x75 → `addr`=0x1B reads 0;
  - make with ext=0, code 0x75 → dropped; queue is still empty the next cycle.
- Overflow (FIFO_DEPTH=8):
  - 10 mapped events on consecutive cycles → 9 queued (the first is popped during its APPLY), `overflow`=1;
  - exactly 9 matrix updates occur, each HOLD_CYCLES+2 apart.
- Shift plus key:
  - make 0x12, then make 0x45 ('0');
  - after both are applied, `addr` 0x35 and 0x20 both read 0, and all other indices read 1.
- Reset mid-hold:
  - assert `reset` during HOLD with 3 events queued;
  - immediately all `key_out`=1, `busy`=0, `overflow`=0;
  - after release, no updates occur until a new toggle.
- Unmapped code:
  - make 0x07 (F12) → `busy` stays 0 and the matrix is unchanged.
